panda_imem: RTL and testbench

//   Instruction-memory responder: the far end of the fetch-address stream produced by the PC stage.
//   - Accepts one fetch address per valid/ready handshake.
//   - Reads a word-addressed instruction RAM with a configurable number of wait cycles.
//   - Returns instruction + originating address on a valid/ready response channel.
//   - flush_i (branch/jump redirect) kills the in-flight access.

---
 rtl/panda_pkg.sv | 16 +
 rtl/panda_imem_ram.sv | 30 +++
 rtl/panda_imem.sv | 153 +++++++++++++++
 tb/tb_panda_imem.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/panda_pkg.sv
// Shared types and constants for the panda fetch path.
//   imem_state_e : instruction-memory responder FSM states
//   InstrNop     : canonical NOP (addi x0, x0, 0) returned on faulting fetches
//   ImemCntW     : width of the responder wait counter (Latency up to 8)
package panda_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } imem_state_e;

    localparam logic [31:0] InstrNop = 32'h0000_0013;
    localparam int unsigned ImemCntW = 3;

endpackage

// File: rtl/panda_imem_ram.sv
// Depth x 32 instruction RAM, single clock.
//   clk_i    : clock
//   re_i     : read enable; rdata_o updates at the edge where re_i is high
//   raddr_i  : read word index
//   rdata_o  : registered read data, held between reads
//   we_i     : write enable
//   waddr_i  : write word index
//   wdata_i  : write data
// A read and a write to the same word in one cycle returns the old word.
module panda_imem_ram #(
    parameter int unsigned Depth = 1024
) (
    input  logic                     clk_i,
    input  logic                     re_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [31:0]              rdata_o,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [31:0]              wdata_i
);

    logic [31:0] mem_q [Depth];

    // Both accesses use the pre-edge array contents, which gives read-first.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/panda_imem.sv
// Instruction-memory responder at the far end of the PC-stage fetch stream.
// One fetch accepted per req handshake; the word comes back Latency edges
// after acceptance on the rsp channel together with its address.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_valid_i/ready_o   : fetch request handshake, req_addr_i byte address
//   flush_i               : redirect; kills in-flight access and pending response
//   rsp_valid_o/ready_i   : response handshake
//   rsp_instr_o/addr_o    : fetched word and its originating address
//   rsp_err_o             : misaligned / out-of-range fetch
//   ld_we_i/addr_i/data_i : image loader write port
// Build option PANDA_IMEM_ERR_EN: when defined, misaligned or out-of-range
// fetches flag rsp_err_o and return InstrNop; otherwise addresses wrap.
module panda_imem
    import panda_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = 1024,
    parameter int unsigned Latency = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [Width-1:0] req_addr_i,
    input  logic             flush_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_instr_o,
    output logic [Width-1:0] rsp_addr_o,
    output logic             rsp_err_o,
    input  logic             ld_we_i,
    input  logic [Width-1:0] ld_addr_i,
    input  logic [31:0]      ld_data_i
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam logic [ImemCntW-1:0] CntInit = ImemCntW'(Latency - 1);

    imem_state_e         state_q, state_d;
    logic [ImemCntW-1:0] cnt_q, cnt_d;
    logic [Width-1:0]    addr_q;
    logic [31:0]         instr_q;
    logic [Width-1:0]    rsp_addr_q;
    logic                rsp_valid_q;
    logic                req_hs;
    logic                rsp_load;
    logic [31:0]         ram_rdata;
    logic [31:0]         instr_d;
    logic                unused_ld_bits;

    // Only the word-index bits of the loader address select a RAM word.
    assign unused_ld_bits = ^ld_addr_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_o = 1'b0;
        rsp_load    = 1'b0;
        case (state_q)
            IDLE: req_ready_o = 1'b1;
            BUSY: begin
                if (cnt_q == '0) begin
                    rsp_load = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - ImemCntW'(1);
                end
            end
            RESP: begin
                // Taking the next fetch while the current one drains keeps
                // the stream gap-free under a ready consumer.
                req_ready_o = rsp_ready_i;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst_i || flush_i) req_ready_o = 1'b0;
        req_hs = req_ready_o && req_valid_i;
        if (req_hs) begin
            state_d = BUSY;
            cnt_d   = CntInit;
        end
        if (flush_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            rsp_load = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            instr_q     <= '0;
            rsp_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (req_hs) addr_q <= req_addr_i;
            if (rsp_load) begin
                instr_q    <= instr_d;
                rsp_addr_q <= addr_q;
            end
            if (flush_i)                              rsp_valid_q <= 1'b0;
            else if (rsp_load)                        rsp_valid_q <= 1'b1;
            else if (state_q == RESP && rsp_ready_i)  rsp_valid_q <= 1'b0;
        end
    end

`ifdef PANDA_IMEM_ERR_EN
    logic req_err;
    logic err_q;
    logic rsp_err_q;

    assign req_err = (req_addr_i[1:0] != 2'b00) || ((req_addr_i >> (IdxW + 2)) != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            if (req_hs)   err_q     <= req_err;
            if (rsp_load) rsp_err_q <= err_q;
        end
    end

    // Faulting fetches still walk the full latency so timing is uniform.
    assign instr_d   = err_q ? InstrNop : ram_rdata;
    assign rsp_err_o = rsp_err_q;
`else
    assign instr_d   = ram_rdata;
    assign rsp_err_o = 1'b0;
`endif

    // The RAM read is launched at acceptance; its output register holds the
    // word until the counter expires, so any Latency >= 1 works.
    panda_imem_ram #(.Depth(Depth)) u_ram (
        .clk_i   (clk_i),
        .re_i    (req_hs),
        .raddr_i (req_addr_i[IdxW+1:2]),
        .rdata_o (ram_rdata),
        .we_i    (ld_we_i && !rst_i),
        .waddr_i (ld_addr_i[IdxW+1:2]),
        .wdata_i (ld_data_i)
    );

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_instr_o = instr_q;
    assign rsp_addr_o  = rsp_addr_q;

endmodule

// File: tb/tb_panda_imem.sv
// Directed bench for panda_imem: one instance at Latency=1 (d1) and one at
// Latency=3 (d3) share all inputs; each test checks the instance it targets.
module tb_panda_imem;

    logic        clk = 1'b0;
    logic        rst, req_valid, flush, rsp_ready, ld_we;
    logic [31:0] req_addr, ld_addr, ld_data;

    logic        d1_req_ready, d1_rsp_valid, d1_rsp_err;
    logic [31:0] d1_rsp_instr, d1_rsp_addr;
    logic        d3_req_ready, d3_rsp_valid, d3_rsp_err;
    logic [31:0] d3_rsp_instr, d3_rsp_addr;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    panda_imem #(.Width(32), .Depth(1024), .Latency(1)) u_d1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(d1_req_ready),
        .req_addr_i(req_addr), .flush_i(flush), .rsp_valid_o(d1_rsp_valid),
        .rsp_ready_i(rsp_ready), .rsp_instr_o(d1_rsp_instr), .rsp_addr_o(d1_rsp_addr),
        .rsp_err_o(d1_rsp_err), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    panda_imem #(.Width(32), .Depth(1024), .Latency(3)) u_d3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(d3_req_ready),
        .req_addr_i(req_addr), .flush_i(flush), .rsp_valid_o(d3_rsp_valid),
        .rsp_ready_i(rsp_ready), .rsp_instr_o(d3_rsp_instr), .rsp_addr_o(d3_rsp_addr),
        .rsp_err_o(d3_rsp_err), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = 32'(idx * 4); ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    // Latency=1 read: valid is low after the acceptance edge, high after the next.
    task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] ei, input logic ee);
        req_valid = 1'b1; req_addr = a;
        tick();
        req_valid = 1'b0;
        tick();
        @(negedge clk);
        chk({tag, "_v"},   d1_rsp_valid, 1);
        chk({tag, "_ins"}, d1_rsp_instr, ei);
        chk({tag, "_adr"}, d1_rsp_addr, a);
        chk({tag, "_err"}, d1_rsp_err, ee);
        repeat (6) tick();
    endtask

    task automatic wait_v3(output bit got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (d3_rsp_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic watch_quiet(input int n, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (d1_rsp_valid || d3_rsp_valid) seen = 1'b1;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          got, seen, bad_v, bad_s, bad_r;
        logic [31:0] held_i, held_a;
        int          idx, nrsp;
        int          acc_c [3];
        logic [31:0] exp_i [3];

        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        ld_we = 1'b0; req_addr = '0; ld_addr = '0; ld_data = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_rdy",   d1_req_ready, 0);
        chk("rst_v",     d1_rsp_valid, 0);
        chk("rst_ins",   d1_rsp_instr, 0);
        chk("rst_adr",   d1_rsp_addr, 0);
        chk("rst_err",   d1_rsp_err, 0);
        chk("rst_v3",    d3_rsp_valid, 0);
        tick();
        rst = 1'b0;

        load(0, 32'h1111_0000);
        load(1, 32'h2222_1111);
        load(2, 32'hDEAD_BEEF);
        load(3, 32'h3333_3333);
        load(4, 32'h4444_4444);
        load(1023, 32'hCAFE_F00D);

        // Reset held three edges while d3 is counting: the access is dropped.
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0; rst = 1'b1;
        bad_v = 1'b0; bad_r = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (d3_rsp_valid) bad_v = 1'b1;
            if (d3_req_ready) bad_r = 1'b1;
            tick();
        end
        rst = 1'b0;
        chk("rst_mid_v", bad_v, 0);
        chk("rst_mid_rdy", bad_r, 0);
        watch_quiet(8, seen);
        chk("rst_no_late_rsp", seen, 0);
        @(negedge clk);
        chk("rst_idle_rdy", d3_req_ready, 1);
        tick();

        // Latency=1 fetch of a loaded word.
        req_valid = 1'b1; req_addr = 32'h8;
        @(negedge clk);
        chk("t2_rdy", d1_req_ready, 1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("t2_v_early", d1_rsp_valid, 0);
        tick();
        @(negedge clk);
        chk("t2_v",   d1_rsp_valid, 1);
        chk("t2_ins", d1_rsp_instr, 32'hDEAD_BEEF);
        chk("t2_adr", d1_rsp_addr, 32'h8);
        chk("t2_err", d1_rsp_err, 0);
        repeat (7) tick();

        // Fetch and loader write of word 3 in the same cycle: old word returned.
        req_valid = 1'b1; req_addr = 32'hC;
        ld_we = 1'b1; ld_addr = 32'hC; ld_data = 32'h9999_9999;
        tick();
        req_valid = 1'b0; ld_we = 1'b0;
        tick();
        @(negedge clk);
        chk("rdfirst_old", d1_rsp_instr, 32'h3333_3333);
        repeat (7) tick();
        rd1("rdfirst_new", 32'hC, 32'h9999_9999, 1'b0);
        rd1("last_word", 32'hFFC, 32'hCAFE_F00D, 1'b0);

        // Latency=3 stream with a ready consumer: each request after the first
        // is accepted in the previous response's cycle, and every response
        // rises three edges after its acceptance edge (4 samples later).
        exp_i[0] = 32'h1111_0000; exp_i[1] = 32'h2222_1111; exp_i[2] = 32'hDEAD_BEEF;
        idx = 0; nrsp = 0;
        for (int c = 0; c < 20; c++) begin
            req_valid = (idx < 3);
            req_addr  = 32'(idx * 4);
            @(negedge clk);
            if (d3_rsp_valid) begin
                if (nrsp < 3) begin
                    chk($sformatf("t3_lat%0d", nrsp), 64'(c - acc_c[nrsp]), 4);
                    chk($sformatf("t3_ins%0d", nrsp), d3_rsp_instr, exp_i[nrsp]);
                    chk($sformatf("t3_adr%0d", nrsp), d3_rsp_addr, 32'(nrsp * 4));
                    if (nrsp < 2) chk($sformatf("t3_b2b%0d", nrsp), 64'(d3_req_ready), 1);
                end
                nrsp++;
            end
            if (req_valid && d3_req_ready) begin
                acc_c[idx] = c;
                idx++;
            end
            tick();
        end
        req_valid = 1'b0;
        chk("t3_nrsp", 64'(nrsp), 3);
        repeat (4) tick();

        // Backpressure on d3.
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h10;
        tick();
        req_addr = 32'h4;
        wait_v3(got);
        chk("bp_got", got, 1);
        chk("bp_ins", d3_rsp_instr, 32'h4444_4444);
        chk("bp_adr", d3_rsp_addr, 32'h10);
        held_i = d3_rsp_instr; held_a = d3_rsp_addr;
        bad_v = 1'b0; bad_s = 1'b0; bad_r = 1'b0;
        repeat (5) begin
            tick();
            @(negedge clk);
            if (!d3_rsp_valid) bad_v = 1'b1;
            if (d3_rsp_instr !== held_i || d3_rsp_addr !== held_a) bad_s = 1'b1;
            if (d3_req_ready) bad_r = 1'b1;
        end
        chk("bp_hold_v", bad_v, 0);
        chk("bp_stable", bad_s, 0);
        chk("bp_no_rdy", bad_r, 0);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_rdy", d3_req_ready, 1);
        tick();
        req_valid = 1'b0;
        wait_v3(got);
        chk("bp2_got", got, 1);
        chk("bp2_ins", d3_rsp_instr, 32'h2222_1111);
        chk("bp2_adr", d3_rsp_addr, 32'h4);
        repeat (6) tick();

        // Flush while d3 is BUSY; a request offered in the flush cycle is refused.
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        flush = 1'b1; req_addr = 32'h8;
        @(negedge clk);
        chk("fl_busy_rdy", d3_req_ready, 0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        watch_quiet(8, seen);
        chk("fl_busy_quiet", seen, 0);

        // Flush while d3 holds a response.
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        wait_v3(got);
        chk("fl_resp_got", got, 1);
        tick();
        flush = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h8;
        @(negedge clk);
        chk("fl_resp_rdy", d3_req_ready, 0);
        tick();
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("fl_resp_v", d3_rsp_valid, 0);
        tick();
        watch_quiet(8, seen);
        chk("fl_resp_quiet", seen, 0);

        req_valid = 1'b1; req_addr = 32'h10;
        tick();
        req_valid = 1'b0;
        wait_v3(got);
        chk("fl_next_got", got, 1);
        chk("fl_next_ins", d3_rsp_instr, 32'h4444_4444);
        chk("fl_next_adr", d3_rsp_addr, 32'h10);
        repeat (6) tick();

        // Misaligned and out-of-range fetches.
`ifdef PANDA_IMEM_ERR_EN
        rd1("mis", 32'h6, 32'h0000_0013, 1'b1);
        rd1("oor", 32'h1000, 32'h0000_0013, 1'b1);
`else
        rd1("mis", 32'h6, 32'h2222_1111, 1'b0);
        rd1("oor", 32'h1000, 32'h1111_0000, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
